// File: rtl/mul_div_sequencer_if.sv
// Handshake and result bus of the HI/LO multiply/divide sequencer.
// start/op/operands are sampled only on the accepting edge; done and hilo_we pulse together for one cycle.
interface mul_div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             hilo_we;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [2:0]       dbg_state;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, hilo_we, div_by_zero, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, hilo_we, div_by_zero, hi, lo, dbg_state
  );
endinterface

// File: rtl/mul_div_sequencer.sv
// Iterative signed Booth multiplier / restoring divider sharing one accumulator+shift datapath.
// Result lands in HI/LO on entry to FINISH; FINISH can accept the next start directly.
module mul_div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  mul_div_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    MUL_ITER = 3'd2,
    DIV_ITER = 3'd3,
    DIV_FIX  = 3'd4,
    FINISH   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic             is_div;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] q_reg;
  logic             q_m1;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             dbz_r;
  logic             accept;

  logic [WIDTH:0]   booth_sum, booth_acc;
  logic [WIDTH-1:0] booth_q;
  logic [WIDTH:0]   div_sh, div_acc;
  logic [WIDTH+1:0] div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] fix_q, fix_r;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  assign accept = ((state == IDLE) || (state == FINISH)) && bus.start && !bus.op[1];

  // Booth step: add/sub by {Q[0], q_-1}, then arithmetic shift of {A, Q, q_-1}.
  always_comb begin
    booth_sum = acc;
    case ({q_reg[0], q_m1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q   = {booth_sum[0], q_reg[WIDTH-1:1]};
  end

  // Restoring divide step on magnitudes; the extra trial bit is the borrow.
  always_comb begin
    div_sh    = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
    div_trial = {1'b0, div_sh} - {1'b0, mcand};
    div_ok    = !div_trial[WIDTH+1];
    div_acc   = div_ok ? div_trial[WIDTH:0] : div_sh;
    div_q     = {q_reg[WIDTH-2:0], div_ok};
    fix_q     = neg_q ? -q_reg : q_reg;
    fix_r     = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FINISH: state_nxt = accept ? LOAD : IDLE;
      LOAD: begin
        if (!is_div)         state_nxt = MUL_ITER;
        else if (q_reg == '0) state_nxt = FINISH;
        else                 state_nxt = DIV_ITER;
      end
      MUL_ITER: if (cnt == '0) state_nxt = FINISH;
      DIV_ITER: if (cnt == '0) state_nxt = DIV_FIX;
      DIV_FIX:  state_nxt = FINISH;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state == LOAD) || (state == MUL_ITER) ||
                      (state == DIV_ITER) || (state == DIV_FIX);
    bus.done        = (state == FINISH);
    bus.hilo_we     = (state == FINISH);
    bus.div_by_zero = dbz_r;
    bus.hi          = hi_r;
    bus.lo          = lo_r;
    bus.dbg_state   = state;
  end

  // Operands are parked in M/Q at accept; LOAD turns them into magnitudes for DIV.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_div <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      q_reg  <= '0;
      q_m1   <= 1'b0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      dbz_r  <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (accept) begin
            is_div <= bus.op[0];
            mcand  <= {bus.operand_a[WIDTH-1], bus.operand_a};
            q_reg  <= bus.operand_b;
          end
        end
        LOAD: begin
          acc  <= '0;
          q_m1 <= 1'b0;
          cnt  <= CNT_LAST;
          if (is_div) begin
            q_reg <= mag(mcand[WIDTH-1:0]);
            mcand <= {1'b0, mag(q_reg)};
            neg_q <= mcand[WIDTH-1] ^ q_reg[WIDTH-1];
            neg_r <= mcand[WIDTH-1];
            if (q_reg == '0) begin
              hi_r  <= mcand[WIDTH-1:0];
              lo_r  <= '1;
              dbz_r <= 1'b1;
            end
          end
        end
        MUL_ITER: begin
          acc   <= booth_acc;
          q_reg <= booth_q;
          q_m1  <= q_reg[0];
          cnt   <= cnt - CNT_ONE;
          if (cnt == '0) begin
            hi_r  <= booth_acc[WIDTH-1:0];
            lo_r  <= booth_q;
            dbz_r <= 1'b0;
          end
        end
        DIV_ITER: begin
          acc   <= div_acc;
          q_reg <= div_q;
          cnt   <= cnt - CNT_ONE;
        end
        DIV_FIX: begin
          hi_r  <= fix_r;
          lo_r  <= fix_q;
          dbz_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer: latency, HI/LO results, div-by-zero, start filtering, reset abort.
module tb_mul_div_sequencer;

  localparam int WIDTH = 32;
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [63:0] exp_q[$];

  mul_div_sequencer_if #(.WIDTH(WIDTH)) bus ();

  mul_div_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver: one start pulse; returns at cycle 1 (#1 after the accepting edge)
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // steps cycles until done; optionally pulses a MUL 9x9 request at cycle inj
  task automatic wait_done(input int inj, output int cyc, output int busy_bad);
    cyc = 1;
    busy_bad = 0;
    while (!bus.done && cyc < 100) begin
      if (cyc == inj) begin
        bus.start = 1'b1; bus.op = OP_MUL; bus.operand_a = 32'd9; bus.operand_b = 32'd9;
      end else if (cyc == inj + 1) begin
        bus.start = 1'b0;
      end
      if (!bus.busy) busy_bad++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // scoreboard: compare FINISH-cycle outputs with the oldest expected HI/LO
  task automatic finish_check(input string tag, input int cyc, input int busy_bad,
                              input int exp_lat, input logic exp_dbz);
    logic [63:0] exp;
    exp = 64'hdead_beef_dead_beef;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy_gap"}, 64'(busy_bad), 64'd0);
    check({tag, "_busy_fin"}, 64'(bus.busy), 64'd0);
    check({tag, "_we"}, 64'(bus.hilo_we), 64'd1);
    check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    check({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input int exp_lat, input logic [31:0] ehi,
                     input logic [31:0] elo, input logic edbz);
    int cyc, bb;
    exp_q.push_back({ehi, elo});
    launch(o, a, b);
    wait_done(0, cyc, bb);
    finish_check(tag, cyc, bb, exp_lat, edbz);
  endtask

  initial begin
    int cyc, bb, dones;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    @(posedge clk); #1;
    check("idle_done", 64'(bus.done), 64'd0);
    check("idle_we", 64'(bus.hilo_we), 64'd0);
    check("idle_hold", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    run("mul_mn_mn", OP_MUL, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run("mul_mx_mn", OP_MUL, 32'h7FFF_FFFF, 32'h8000_0000, 34, 32'hC000_0000, 32'h8000_0000, 1'b0);
    run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("div_mn_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'h0, 32'h8000_0000, 1'b0);
    run("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 35, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run("div_5_0", OP_DIV, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run("mul_2_3", OP_MUL, 32'd2, 32'd3, 34, 32'd0, 32'd6, 1'b0);

    // illegal op is ignored
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b10; bus.operand_a = 32'd1; bus.operand_b = 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("illegal_busy", 64'(bus.busy), 64'd0);
    check("illegal_state", 64'(bus.dbg_state), 64'd0);

    // stray start mid-run is ignored; start held in FINISH is taken with no gap
    exp_q.push_back({32'd0, 32'd12});
    launch(OP_MUL, 32'd3, 32'd4);
    wait_done(10, cyc, bb);
    finish_check("mul_3_4_inj", cyc, bb, 34, 1'b0);
    exp_q.push_back({32'd2, 32'd14});
    bus.start = 1'b1; bus.op = OP_DIV; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(0, cyc, bb);
    finish_check("div_100_7_b2b", cyc, bb, 35, 1'b0);

    // reset mid-MUL discards the operation
    launch(OP_MUL, 32'd3, 32'd5);
    for (int i = 1; i < 15; i++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("arst_no_done", 64'(dones), 64'd0);

    run("mul_m1_m1", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'd0, 32'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
- Iterative signed multiply/divide unit for the CPU's HI/LO path.
- Sequences a radix-2 Booth multiplier and a shift-subtract divider over one shared accumulator/shift datapath. The two operations are never active at the same time.
- Accepts one operation per start handshake, runs it over multiple cycles, and writes the 2×WIDTH result to the HI/LO outputs with a one-cycle write strobe.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE or FINISH
- op  input  2  00 = MUL signed, 01 = DIV signed, 1x = illegal (start ignored)
- operand_a  input  WIDTH  multiplicand / dividend
- operand_b  input  WIDTH  multiplier / divisor
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- hilo_we  output  1  HI/LO write strobe; identical timing to done
- div_by_zero  output  1  valid with done; 1 only for DIV with operand_b = 0
- hi  output  WIDTH  MUL: upper product; DIV: remainder
- lo  output  WIDTH  MUL: lower product; DIV: quotient

Behaviour:
- Reset (rst = 0, asynchronous): state goes to IDLE immediately.
  - All outputs and internal registers are cleared to 0.
  - An in-flight operation is discarded; no done pulse is issued for it.
- States: IDLE, LOAD, MUL_ITER, DIV_ITER, DIV_FIX, FINISH.
- Handshake: start is accepted when state is IDLE or FINISH, start = 1 and op[1] = 0. Operands and op are latched on that edge and the next state is LOAD.
  - start is ignored in every other state and for op = 1x.
- Cycle numbering: cycle 0 is the cycle start is sampled.
  - MUL: LOAD in cycle 1, MUL_ITER in cycles 2..33, FINISH in cycle 34. Latency is 34.
  - DIV: LOAD in cycle 1, DIV_ITER in cycles 2..33, DIV_FIX in cycle 34, FINISH in cycle 35. Latency is 35.
  - DIV by zero: LOAD in cycle 1, then FINISH in cycle 2.
- busy = 1 in LOAD, MUL_ITER, DIV_ITER and DIV_FIX; busy = 0 in IDLE and FINISH.
- done = hilo_we = 1 only in FINISH. FINISH returns to IDLE unless a new start is accepted, so back-to-back operations have zero dead cycles.
- hi/lo update only on entry to FINISH and hold their value otherwise, including through IDLE and while busy.
- div_by_zero updates together with hi/lo.
- Iteration counter: loaded with WIDTH-1 in LOAD and decremented each iteration. The last iteration is taken when counter = 0.
- MUL (Booth):
  - Accumulator A is WIDTH+1 bits, sign-extended, so that M = most-negative does not overflow. A is cleared in LOAD.
  - Q = operand_b, q_-1 = 0, M = operand_a sign-extended to WIDTH+1 bits.
  - Each iteration, look at {Q[0], q_-1}: 01 → A = A + M; 10 → A = A − M; 00 and 11 → no add.
  - Then arithmetic-shift {A, Q, q_-1} right by 1.
  - Result: hi = A[WIDTH-1:0], lo = Q. This is the exact signed 2×WIDTH product.
- DIV:
  - LOAD converts both operands to unsigned magnitudes and records the quotient sign (sign_a XOR sign_b) and the remainder sign (sign_a).
  - DIV_ITER runs restoring shift-subtract on the magnitudes, one quotient bit per cycle.
  - DIV_FIX negates the quotient and remainder as required by the recorded signs.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - most-negative / −1: lo = most-negative, hi = 0 (wraps silently, no flag).
- DIV by zero: detected in LOAD. Result is hi = operand_a, lo = all ones, div_by_zero = 1.
- div_by_zero = 0 for every MUL and every non-zero DIV.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3) → done in cycle 34 only; busy high in cycles 1..33; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; hilo_we coincident with done.
- MUL 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0x00000000; then MUL 0x7FFFFFFF × 0x80000000 → hi = 0xC0000000, lo = 0x80000000.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → done in cycle 35; lo = 0xFFFFFFFD, hi = 0xFFFFFFFF, div_by_zero = 0; then DIV 0x80000000 ÷ 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIV 5 ÷ 0 → done in cycle 2; hi = 5, lo = 0xFFFFFFFF, div_by_zero = 1; next MUL 2 × 3 → div_by_zero = 0, hi = 0, lo = 6.
- Start MUL 3 × 4, pulse start with MUL 9 × 9 in cycle 10 → second request ignored; result hi = 0, lo = 12. Hold start high with DIV 100 ÷ 7 in the FINISH cycle → accepted; lo = 14, hi = 2 after 35 more cycles.
- Assert rst in cycle 15 of a MUL → busy, done, hi and lo = 0 immediately, no done pulse; after release, MUL −1 × −1 → hi = 0, lo = 1.
